// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the MEM pipeline stage and its data RAM.
//   memState_t      - access FSM encoding (IDLE / ACCESS)
//   JUMP_IF_ZERO    - Neq sense value that selects "branch when ALU result is zero"
//   JUMP_IF_NONZERO - Neq sense value that selects "branch when ALU result is non-zero"
//   CNT_W           - width of the access-latency counter (MEM_LAT range 1..15)
package mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memState_t;

  localparam logic JUMP_IF_ZERO    = 1'b0;
  localparam logic JUMP_IF_NONZERO = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_ram_p.sv
// mem_ram_p: single-port synchronous data RAM, DATA_W x DEPTH, no reset on
// contents so it maps onto block RAM.
//   clock  in  rising-edge clock
//   rdEn   in  register RAM[addr] into rdData on this edge
//   wrEn   in  write wrData into RAM[addr] on this edge
//   addr   in  word address
//   wrData in  write data
//   rdData out registered read data; holds between reads
// A simultaneous read and write of the same word returns the old contents
// (read-before-write).
module mem_ram_p #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              rdEn,
  input  logic              wrEn,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (rdEn) begin
      rdData <= mem[addr];
    end
    if (wrEn) begin
      mem[addr] <= wrData;
    end
  end

endmodule

// File: rtl/mem_stage_p.sv
// mem_stage_p: MEM pipeline stage with a multi-cycle internal data RAM.
//   clock       in  rising-edge clock
//   reset_n     in  asynchronous active-low reset
//   ex_valid    in  EX presents a valid instruction
//   Wr/Wm/Rm    in  register write / store / load controls
//   J/JC/Neq    in  jump, conditional jump, condition sense
//   zeroOut     in  ALU zero flag
//   acOutValue  in  ALU result / memory address
//   RegVal      in  store data
//   stall_o     out stage register holding this edge (upstream must hold)
//   saidaA      out branch taken, one pulse per captured instruction
//   wb_valid    out result register valid this cycle
//   Wr_MEM      out registered Wr
//   Rm_MEM      out registered Rm
//   data_out    out load data when Rm_MEM, else registered ALU result
//   fault_o     out out-of-range access, pulses with wb_valid
// Optional feature macro: MEM_RANGE_CHECK_EN. When defined, addresses >= DEPTH
// fault (store suppressed, load returns 0); otherwise addresses wrap modulo
// DEPTH and fault_o is tied low.
module mem_stage_p
  import mem_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              Wr,
  input  logic              Wm,
  input  logic              Rm,
  input  logic              J,
  input  logic              JC,
  input  logic              Neq,
  input  logic              zeroOut,
  input  logic [DATA_W-1:0] acOutValue,
  input  logic [DATA_W-1:0] RegVal,
  output logic              stall_o,
  output logic              saidaA,
  output logic              wb_valid,
  output logic              Wr_MEM,
  output logic              Rm_MEM,
  output logic [DATA_W-1:0] data_out,
  output logic              fault_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Stage register
  logic              validS, wrS, wmS, rmS, jS, jcS, neqS, zeroS;
  logic [DATA_W-1:0] acS, regValS;
  logic              freshS;  // first cycle after a capture

  // Access FSM
  memState_t         state;
  logic [CNT_W-1:0]  cnt;

  // Result register
  logic              wbValidR, wrMemR, rmMemR;
  logic [DATA_W-1:0] aluR;

  logic              stall, done, memOpS, memFault;
  logic [ADDR_W-1:0] addrFull;
  logic [IDX_W-1:0]  ramAddr;
  logic [DATA_W-1:0] ramQ;

  assign stall    = (state == ACCESS) && (cnt > CNT_W'(1));
  // Completion edge of an in-flight access: the counter is on its last cycle.
  assign done     = (state == ACCESS) && (cnt == CNT_W'(1));
  assign memOpS   = rmS | wmS;
  assign addrFull = acS[ADDR_W-1:0];
  assign ramAddr  = addrFull[IDX_W-1:0];
  assign stall_o  = stall;

`ifdef MEM_RANGE_CHECK_EN
  assign memFault = (32'(addrFull) >= 32'(DEPTH));
`else
  assign memFault = 1'b0;
`endif

  // Gated by freshS so a branch held in the stage under stall pulses once only.
  assign saidaA = freshS & validS &
                  (jS | (jcS & ((neqS == JUMP_IF_NONZERO) ? ~zeroS : zeroS)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      validS  <= 1'b0;
      wrS     <= 1'b0;
      wmS     <= 1'b0;
      rmS     <= 1'b0;
      jS      <= 1'b0;
      jcS     <= 1'b0;
      neqS    <= 1'b0;
      zeroS   <= 1'b0;
      acS     <= '0;
      regValS <= '0;
      freshS  <= 1'b0;
    end else begin
      freshS <= !stall;
      if (!stall) begin
        // A bubble enters with every control cleared.
        validS  <= ex_valid;
        wrS     <= ex_valid & Wr;
        wmS     <= ex_valid & Wm;
        rmS     <= ex_valid & Rm;
        jS      <= ex_valid & J;
        jcS     <= ex_valid & JC;
        neqS    <= ex_valid & Neq;
        zeroS   <= ex_valid & zeroOut;
        acS     <= acOutValue;
        regValS <= RegVal;
      end
    end
  end

  // The FSM follows the instruction being captured: whenever the stage is
  // free to load, the next state is decided by the incoming ex_* controls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (stall) begin
      cnt <= cnt - CNT_W'(1);
    end else if (ex_valid && (Rm || Wm)) begin
      state <= ACCESS;
      cnt   <= CNT_W'(MEM_LAT);
    end else begin
      state <= IDLE;
      cnt   <= '0;
    end
  end

  // Store commits only at the completion edge, so a reset during the
  // access aborts it without touching the RAM.
  mem_ram_p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) uRam (
    .clock  (clock),
    .rdEn   (done & rmS),
    .wrEn   (done & wmS & ~memFault),
    .addr   (ramAddr),
    .wrData (regValS),
    .rdData (ramQ)
  );

  // Loads whenever the stage advances: that edge completes the held instruction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wbValidR <= 1'b0;
      wrMemR   <= 1'b0;
      rmMemR   <= 1'b0;
      aluR     <= '0;
    end else begin
      wbValidR <= !stall & validS;
      if (!stall) begin
        wrMemR <= wrS;
        rmMemR <= rmS;
        aluR   <= acS;
      end
    end
  end

  assign wb_valid = wbValidR;
  assign Wr_MEM   = wrMemR;
  assign Rm_MEM   = rmMemR;

`ifdef MEM_RANGE_CHECK_EN
  logic faultR;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      faultR <= 1'b0;
    end else if (!stall) begin
      faultR <= memOpS & memFault;
    end
  end

  assign fault_o  = faultR & wbValidR;
  assign data_out = rmMemR ? (faultR ? '0 : ramQ) : aluR;
`else
  assign fault_o  = 1'b0;
  assign data_out = rmMemR ? ramQ : aluR;
`endif

endmodule

// File: tb/tb_mem_stage_p.sv
// tb_mem_stage_p: directed bench for mem_stage_p. Three instances share the
// input bus: index 0 MEM_LAT=1, index 1 MEM_LAT=3, index 2 MEM_LAT=4/DEPTH=64.
// Honours MEM_RANGE_CHECK_EN for the out-of-range expectations.
module tb_mem_stage_p;

`ifdef MEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetN;
  logic       exValid, wr, wm, rm, j, jc, neq, zero;
  logic [7:0] acVal, regVal;

  logic       stallO [3];
  logic       saida  [3];
  logic       wbv    [3];
  logic       wrMem  [3];
  logic       rmMem  [3];
  logic       faultO [3];
  logic [7:0] dataOut[3];

  int passCount  = 0;
  int checkCount = 0;

  always #5 clock = ~clock;

  mem_stage_p #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .MEM_LAT(1)) u1 (
    .clock(clock), .reset_n(resetN), .ex_valid(exValid), .Wr(wr), .Wm(wm), .Rm(rm),
    .J(j), .JC(jc), .Neq(neq), .zeroOut(zero), .acOutValue(acVal), .RegVal(regVal),
    .stall_o(stallO[0]), .saidaA(saida[0]), .wb_valid(wbv[0]), .Wr_MEM(wrMem[0]),
    .Rm_MEM(rmMem[0]), .data_out(dataOut[0]), .fault_o(faultO[0]));

  mem_stage_p #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .MEM_LAT(3)) u3 (
    .clock(clock), .reset_n(resetN), .ex_valid(exValid), .Wr(wr), .Wm(wm), .Rm(rm),
    .J(j), .JC(jc), .Neq(neq), .zeroOut(zero), .acOutValue(acVal), .RegVal(regVal),
    .stall_o(stallO[1]), .saidaA(saida[1]), .wb_valid(wbv[1]), .Wr_MEM(wrMem[1]),
    .Rm_MEM(rmMem[1]), .data_out(dataOut[1]), .fault_o(faultO[1]));

  mem_stage_p #(.DATA_W(8), .ADDR_W(8), .DEPTH(64), .MEM_LAT(4)) u4 (
    .clock(clock), .reset_n(resetN), .ex_valid(exValid), .Wr(wr), .Wm(wm), .Rm(rm),
    .J(j), .JC(jc), .Neq(neq), .zeroOut(zero), .acOutValue(acVal), .RegVal(regVal),
    .stall_o(stallO[2]), .saidaA(saida[2]), .wb_valid(wbv[2]), .Wr_MEM(wrMem[2]),
    .Rm_MEM(rmMem[2]), .data_out(dataOut[2]), .fault_o(faultO[2]));

  typedef struct {
    logic       v, wr, wm, rm, j, jc, neq, z;
    logic [7:0] ac, rv;
    logic       eSaida, eWbv, eWr, eRm;
    logic [7:0] eData;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mkVec(input logic v, wrI, wmI, rmI, jI, jcI, neqI, zI,
                                 input logic [7:0] ac, rv,
                                 input logic eS, eW, eWr, eRm, input logic [7:0] eD);
    vec_t r;
    r.v = v; r.wr = wrI; r.wm = wmI; r.rm = rmI; r.j = jI; r.jc = jcI; r.neq = neqI; r.z = zI;
    r.ac = ac; r.rv = rv;
    r.eSaida = eS; r.eWbv = eW; r.eWr = eWr; r.eRm = eRm; r.eData = eD;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setIn(input logic v, wrI, wmI, rmI, jI, jcI, neqI, zI,
                       input logic [7:0] ac, rv);
    exValid = v; wr = wrI; wm = wmI; rm = rmI; j = jI; jc = jcI; neq = neqI; zero = zI;
    acVal = ac; regVal = rv;
  endtask

  task automatic bubble();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic doReset();
    resetN = 1'b0;
    bubble();
    tick();
    tick();
    resetN = 1'b1;
  endtask

  // Present an instruction and clock until instance sel has captured it.
  task automatic issue(input int sel, input logic v, wrI, wmI, rmI, jI, jcI, neqI, zI,
                       input logic [7:0] ac, rv);
    int n = 0;
    setIn(v, wrI, wmI, rmI, jI, jcI, neqI, zI, ac, rv);
    while (stallO[sel] === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("issue_stall_bound", 32'(n < 40), 32'd1);
    tick();
  endtask

  // Clock until instance sel shows wb_valid; bounded.
  task automatic waitWb(input int sel, output logic [7:0] d, output logic f);
    bit got = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (wbv[sel] === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("wb_valid_timeout", 32'(got), 32'd1);
    d = dataOut[sel];
    f = faultO[sel];
    $display("wb inst%0d: data_out=%02h fault_o=%0b", sel, d, f);
  endtask

  task automatic checkAllZero(input int sel, input string tag);
    check({tag, "_stall"},  32'(stallO[sel]),  32'd0);
    check({tag, "_saidaA"}, 32'(saida[sel]),   32'd0);
    check({tag, "_wbv"},    32'(wbv[sel]),     32'd0);
    check({tag, "_WrMEM"},  32'(wrMem[sel]),   32'd0);
    check({tag, "_RmMEM"},  32'(rmMem[sel]),   32'd0);
    check({tag, "_data"},   32'(dataOut[sel]), 32'd0);
    check({tag, "_fault"},  32'(faultO[sel]),  32'd0);
  endtask

  logic       expStall3[8];
  logic       expWbv3[8];
  logic [7:0] expData3[8];
  logic [7:0] rdData;
  logic       rdFault;

  initial begin
    // Reset state on all instances
    resetN = 1'b0;
    bubble();
    tick();
    tick();
    checkAllZero(0, "rst_i0");
    checkAllZero(1, "rst_i1");
    checkAllZero(2, "rst_i2");
    resetN = 1'b1;

    // MEM_LAT=1 table: expected outputs just after each vector's capture edge
    //                 v  wr wm rm j  jc neq z   ac     rv      sA wbv Wr Rm data
    tbl[0]  = mkVec(1, 1, 0, 0, 0, 0, 0, 0, 8'h3C, 8'h00,  0, 0, 0, 0, 8'h00);
    tbl[1]  = mkVec(1, 0, 1, 0, 0, 0, 0, 0, 8'h10, 8'hA5,  0, 1, 1, 0, 8'h3C);
    tbl[2]  = mkVec(1, 1, 0, 1, 0, 0, 0, 0, 8'h10, 8'h00,  0, 1, 0, 0, 8'h10);
    tbl[3]  = mkVec(1, 0, 0, 0, 0, 1, 1, 0, 8'h77, 8'h00,  1, 1, 1, 1, 8'hA5);
    tbl[4]  = mkVec(1, 0, 0, 0, 0, 1, 1, 1, 8'h01, 8'h00,  0, 1, 0, 0, 8'h77);
    tbl[5]  = mkVec(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00,  0, 1, 0, 0, 8'h01);
    tbl[6]  = mkVec(1, 0, 0, 0, 1, 0, 0, 0, 8'h02, 8'h00,  1, 0, 0, 0, 8'h00);
    tbl[7]  = mkVec(1, 0, 0, 0, 0, 1, 0, 1, 8'h03, 8'h00,  1, 1, 0, 0, 8'h02);
    tbl[8]  = mkVec(1, 0, 1, 1, 0, 0, 0, 0, 8'h10, 8'h5A,  0, 1, 0, 0, 8'h03);
    tbl[9]  = mkVec(1, 1, 0, 1, 0, 0, 0, 0, 8'h10, 8'h00,  0, 1, 0, 1, 8'hA5);
    tbl[10] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00,  0, 1, 1, 1, 8'h5A);
    tbl[11] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00,  0, 0, 0, 0, 8'h00);

    for (int k = 0; k < 12; k++) begin
      setIn(tbl[k].v, tbl[k].wr, tbl[k].wm, tbl[k].rm, tbl[k].j, tbl[k].jc,
            tbl[k].neq, tbl[k].z, tbl[k].ac, tbl[k].rv);
      tick();
      $display("vec %0d: stall_o=%0b saidaA=%0b wb_valid=%0b Wr_MEM=%0b Rm_MEM=%0b data_out=%02h",
               k, stallO[0], saida[0], wbv[0], wrMem[0], rmMem[0], dataOut[0]);
      check($sformatf("v%0d_stall", k),  32'(stallO[0]), 32'd0);
      check($sformatf("v%0d_saidaA", k), 32'(saida[0]),  32'(tbl[k].eSaida));
      check($sformatf("v%0d_wbv", k),    32'(wbv[0]),    32'(tbl[k].eWbv));
      check($sformatf("v%0d_WrMEM", k),  32'(wrMem[0]),  32'(tbl[k].eWr));
      check($sformatf("v%0d_RmMEM", k),  32'(rmMem[0]),  32'(tbl[k].eRm));
      check($sformatf("v%0d_fault", k),  32'(faultO[0]), 32'd0);
      if (tbl[k].eWbv) check($sformatf("v%0d_data", k), 32'(dataOut[0]), 32'(tbl[k].eData));
    end

    // MEM_LAT=3: two stores, then back-to-back loads
    doReset();
    issue(1, 1, 0, 1, 0, 0, 0, 0, 0, 8'h20, 8'h11);
    issue(1, 1, 0, 1, 0, 0, 0, 0, 0, 8'h21, 8'h22);
    bubble();
    repeat (6) tick();
    expStall3 = '{1, 1, 0, 1, 1, 0, 0, 0};
    expWbv3   = '{0, 0, 0, 1, 0, 0, 1, 0};
    expData3  = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h22, 8'h00};
    setIn(1, 1, 0, 1, 0, 0, 0, 0, 8'h20, 8'h00);
    tick();
    for (int c = 0; c < 8; c++) begin
      $display("lat3 cycle %0d: stall_o=%0b wb_valid=%0b data_out=%02h",
               c, stallO[1], wbv[1], dataOut[1]);
      check($sformatf("l3c%0d_stall", c), 32'(stallO[1]), 32'(expStall3[c]));
      check($sformatf("l3c%0d_wbv", c),   32'(wbv[1]),    32'(expWbv3[c]));
      if (expWbv3[c]) check($sformatf("l3c%0d_data", c), 32'(dataOut[1]), 32'(expData3[c]));
      if (c == 0) setIn(1, 1, 0, 1, 0, 0, 0, 0, 8'h21, 8'h00);
      if (c == 3) bubble();
      if (c < 7) tick();
    end

    // MEM_LAT=3: jump that is also a load pulses saidaA once despite the stall
    setIn(1, 1, 0, 1, 1, 0, 0, 0, 8'h20, 8'h00);
    tick();
    check("jmpld_c0_saidaA", 32'(saida[1]), 32'd1);
    bubble();
    tick();
    check("jmpld_c1_saidaA", 32'(saida[1]), 32'd0);
    tick();
    check("jmpld_c2_saidaA", 32'(saida[1]), 32'd0);
    tick();
    check("jmpld_c3_saidaA", 32'(saida[1]), 32'd0);
    check("jmpld_c3_wbv",    32'(wbv[1]),   32'd1);
    check("jmpld_c3_data",   32'(dataOut[1]), 32'h11);
    $display("jump+load: data_out=%02h", dataOut[1]);

    // MEM_LAT=4, DEPTH=64: seed RAM[0x10]=0x00, then reset in the middle of a store
    doReset();
    issue(2, 1, 0, 1, 0, 0, 0, 0, 0, 8'h10, 8'h00);
    bubble();
    waitWb(2, rdData, rdFault);
    issue(2, 1, 0, 1, 0, 0, 0, 0, 0, 8'h10, 8'hEE);
    tick();
    tick();
    resetN = 1'b0;
    bubble();
    #1;
    checkAllZero(2, "midstore_rst");
    tick();
    tick();
    resetN = 1'b1;
    issue(2, 1, 1, 0, 1, 0, 0, 0, 0, 8'h10, 8'h00);
    bubble();
    waitWb(2, rdData, rdFault);
    check("after_rst_ram10", 32'(rdData), 32'h00);
    check("after_rst_fault", 32'(rdFault), 32'd0);

    // Store beyond DEPTH: fault or wrap
    issue(2, 1, 0, 1, 0, 0, 0, 0, 0, 8'h50, 8'h77);
    bubble();
    waitWb(2, rdData, rdFault);
    check("range_store_fault", 32'(rdFault), 32'(RANGE_EN));
    issue(2, 1, 1, 0, 1, 0, 0, 0, 0, 8'h10, 8'h00);
    bubble();
    waitWb(2, rdData, rdFault);
    check("range_ram10", 32'(rdData), RANGE_EN ? 32'h00 : 32'h77);
    check("range_ram10_fault", 32'(rdFault), 32'd0);
    issue(2, 1, 1, 0, 1, 0, 0, 0, 0, 8'h50, 8'h00);
    bubble();
    waitWb(2, rdData, rdFault);
    check("range_load_data", 32'(rdData), RANGE_EN ? 32'h00 : 32'h77);
    check("range_load_fault", 32'(rdFault), 32'(RANGE_EN));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passCount, checkCount);
    $fatal(1);
  end

endmodule
